// File: rtl/equality_stream.sv
// equality_stream: registered masked comparator (eq/neq/lt/gt) on valid/ready streams with a saturating match counter.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, a, b, mode, signed_cmp, mask : input pair stream and its compare controls
//   out_valid/out_ready, result, eq, lt, gt         : one-deep registered result stream
//   clr_count, match_count, count_sat                : true-result counter, sticky saturation flag
module equality_stream #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   input  logic             signed_cmp,
   input  logic [WIDTH-1:0] mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic             eq,
   output logic             lt,
   output logic             gt,
   input  logic             clr_count,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] am, bm;
   logic             eq_c, lt_c, gt_c, res_c, accept;
   logic [CNT_W-1:0] cnt_inc;

   assign am = a & mask;
   assign bm = b & mask;
   assign out_valid = (state == FULL);
   assign in_ready = !out_valid || out_ready;
   assign accept = in_valid && in_ready;
   assign cnt_inc = match_count + CNT_W'(1);

   // The sign bit is taken from the masked operand, so masking it off makes the value non-negative.
   always_comb begin
      eq_c = (am == bm);
      lt_c = signed_cmp ? ($signed(am) < $signed(bm)) : (am < bm);
      gt_c = !eq_c && !lt_c;
      res_c = mode[1] ? (mode[0] ? gt_c : lt_c) : (mode[0] ? !eq_c : eq_c);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
         result <= 1'b0;
         eq <= 1'b0;
         lt <= 1'b0;
         gt <= 1'b0;
      end else if (accept) begin
         state <= FULL;
         result <= res_c;
         eq <= eq_c;
         lt <= lt_c;
         gt <= gt_c;
      end else if (out_ready) begin
         state <= EMPTY;
      end
   end

   // Clear has priority, so a true pair accepted in the clear cycle is not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_count <= '0;
         count_sat <= 1'b0;
      end else if (clr_count) begin
         match_count <= '0;
         count_sat <= 1'b0;
      end else if (accept && res_c && !count_sat) begin
         match_count <= cnt_inc;
         count_sat <= &cnt_inc;
      end
   end
endmodule

// File: tb/tb_equality_stream.sv
// tb_equality_stream: directed self-checking bench for equality_stream (default and CNT_W=2 instances).
module tb_equality_stream;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [3:0] a = '0, b = '0, mask = 4'hF;
   logic [1:0] mode = 2'b00;
   logic       signed_cmp = 1'b0;
   logic       clr_count = 1'b0;
   logic       in_ready, out_valid, result, eq, lt, gt, count_sat;
   logic [7:0] match_count;
   logic       in_ready2, out_valid2, result2, eq2, lt2, gt2, sat2;
   logic [1:0] cnt2;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [3:0] a, b, mask;
      logic [1:0] mode;
      logic       sc;
      logic       res, eq, lt, gt;
   } vec_t;

   equality_stream #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .mode(mode), .signed_cmp(signed_cmp), .mask(mask), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .eq(eq), .lt(lt), .gt(gt),
      .clr_count(clr_count), .match_count(match_count), .count_sat(count_sat));

   equality_stream #(.WIDTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
      .mode(mode), .signed_cmp(signed_cmp), .mask(mask), .out_valid(out_valid2),
      .out_ready(out_ready), .result(result2), .eq(eq2), .lt(lt2), .gt(gt2),
      .clr_count(clr_count), .match_count(cnt2), .count_sat(sat2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t vecs[11];
      vecs[0]  = '{4'h8, 4'h1, 4'hF, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{4'h8, 4'h1, 4'hF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{4'hA, 4'h8, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{4'hA, 4'h8, 4'hD, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{4'hA, 4'h8, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{4'h3, 4'h3, 4'hF, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{4'h3, 4'h2, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{4'h7, 4'hF, 4'hF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{4'hF, 4'hE, 4'hF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{4'hC, 4'h4, 4'h7, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{4'h8, 4'h0, 4'h8, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", {result, eq, lt, gt}, 0);
      chk("rst_count", {count_sat, match_count}, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 1'b0;
      step();

      // exhaustive equality sweep, one pair per cycle
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'(i);
         a = v[7:4];
         b = v[3:0];
         step();
         chk($sformatf("sweep_valid_%0d", i), out_valid, 1);
         chk($sformatf("sweep_res_%0d", i), result, (v[7:4] == v[3:0]));
      end
      chk("sweep_count", match_count, 16);

      // directed compare vectors
      for (int i = 0; i < 11; i++) begin
         a = vecs[i].a;
         b = vecs[i].b;
         mask = vecs[i].mask;
         mode = vecs[i].mode;
         signed_cmp = vecs[i].sc;
         step();
         chk($sformatf("vec%0d_res", i), result, vecs[i].res);
         chk($sformatf("vec%0d_flags", i), {eq, lt, gt}, {vecs[i].eq, vecs[i].lt, vecs[i].gt});
      end

      // backpressure
      clr_count = 1'b1;
      in_valid = 1'b0;
      step();
      clr_count = 1'b0;
      chk("clr_count", {count_sat, match_count}, 0);
      a = 4'h5; b = 4'h5; mask = 4'hF; mode = 2'b00; signed_cmp = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_res", result, 1);
      chk("bp_in_ready", in_ready, 0);
      a = 4'h1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("bp_hold_res_%0d", i), result, 1);
         chk($sformatf("bp_hold_ready_%0d", i), in_ready, 0);
         chk($sformatf("bp_hold_count_%0d", i), match_count, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", in_ready, 1);
      step();
      chk("bp_next_res", result, 0);
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_count", match_count, 1);
      in_valid = 1'b0;
      step();
      chk("drain_valid", out_valid, 0);

      // saturation on the CNT_W=2 instance
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      chk("sat_clr", {sat2, cnt2}, 0);
      a = 4'h6; b = 4'h6;
      in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("sat_cnt_%0d", k), cnt2, (k >= 3) ? 3 : k);
         chk($sformatf("sat_flag_%0d", k), sat2, (k >= 3));
      end
      clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      chk("sat_clr_win", {sat2, cnt2}, 0);
      chk("sat_clr_big", match_count, 0);
      chk("sat_clr_pipe", {out_valid2, result2}, 2'b11);

      // async reset while FULL and stalled
      out_ready = 1'b0;
      step();
      chk("ar_full", out_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_flags", {result, eq, lt, gt}, 0);
      chk("ar_count", {count_sat, match_count}, 0);
      chk("ar_in_ready", in_ready, 1);
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("ar_after", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
